// File: rtl/clock_pkg.sv
// Shared types, hour-mode constants, reset times and BCD helpers for the
// time-of-day core.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned HOUR_12 = 12;
  localparam int unsigned HOUR_24 = 24;

  localparam bcd_t RST_HR12_TENS = 4'd1;
  localparam bcd_t RST_HR12_ONES = 4'd2;
  localparam bcd_t RST_HR24_TENS = 4'd0;
  localparam bcd_t RST_HR24_ONES = 4'd0;

  // Single-digit BCD increment; 9 (or any illegal code) wraps to 0.
  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD modulo-60 counter shared by the seconds and minutes fields.
module bcd_mod60
  import clock_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output bcd_t ones_o,
  output bcd_t tens_o,
  output logic wrap_o
);

  bcd_t ones_q, ones_d;
  bcd_t tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    wrap_o = inc_i && !clr_i && (ones_q == 4'd9) && (tens_q == 4'd5);
    if (clr_i) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (inc_i) begin
      ones_d = bcd_inc(ones_q);
      if (ones_q == 4'd9) tens_d = (tens_q >= 4'd5) ? 4'd0 : tens_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones_o = ones_q;
  assign tens_o = tens_q;

endmodule

// File: rtl/clock_timekeeper.sv
// BCD time-of-day core: 1 Hz prescaler, sec/min/hour counters, manual set
// with carry-safe pending bits, and HH:MM alarm compare.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned HOUR_MODE = 12
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic min_inc_i,
  input  logic hr_inc_i,
  input  logic sec_clr_i,
  input  logic alarm_en_i,
  input  bcd_t alarm_hr_t_i,
  input  bcd_t alarm_hr_o_i,
  input  bcd_t alarm_min_t_i,
  input  bcd_t alarm_min_o_i,
  input  logic alarm_pm_i,
  output bcd_t sec_ones_o,
  output bcd_t sec_tens_o,
  output bcd_t min_ones_o,
  output bcd_t min_tens_o,
  output bcd_t hr_ones_o,
  output bcd_t hr_tens_o,
  output logic pm_o,
  output logic sec_tick_o,
  output logic alarm_o
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam bit Mode24 = (HOUR_MODE == HOUR_24);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end
  if (HOUR_MODE != HOUR_12 && HOUR_MODE != HOUR_24) begin : g_bad_mode
    $error("HOUR_MODE must be 12 or 24");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic tick, sec_wrap, min_wrap, min_apply, hr_carry, hr_apply, hr_step;
  logic min_req, hr_req;
  logic min_prev_q, hr_prev_q, min_pend_q, min_pend_d, hr_pend_q, hr_pend_d;
  logic sec_tick_q, alarm_q, alarm_d, pm_q, pm_d;
  bcd_t hr_tens_q, hr_tens_d, hr_ones_q, hr_ones_d;

  assign tick    = (presc_q == PW'(TICK_DIV - 1)) && !sec_clr_i;
  assign presc_d = (sec_clr_i || tick) ? '0 : presc_q + PW'(1);

  // A manual request waits while a carry targets the same field.
  assign min_req    = min_pend_q | (min_inc_i & ~min_prev_q);
  assign min_apply  = min_req & ~sec_wrap;
  assign min_pend_d = min_req & sec_wrap;
  assign hr_carry   = sec_wrap & min_wrap;
  assign hr_req     = hr_pend_q | (hr_inc_i & ~hr_prev_q);
  assign hr_apply   = hr_req & ~hr_carry;
  assign hr_pend_d  = hr_req & hr_carry;
  assign hr_step    = hr_carry | hr_apply;

  bcd_mod60 u_sec (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (tick),
    .clr_i  (sec_clr_i),
    .ones_o (sec_ones_o),
    .tens_o (sec_tens_o),
    .wrap_o (sec_wrap)
  );

  // Manual minute steps never carry: min_apply is masked whenever sec_wrap is high.
  bcd_mod60 u_min (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (sec_wrap | min_apply),
    .clr_i  (1'b0),
    .ones_o (min_ones_o),
    .tens_o (min_tens_o),
    .wrap_o (min_wrap)
  );

  always_comb begin
    hr_tens_d = hr_tens_q;
    hr_ones_d = hr_ones_q;
    pm_d      = pm_q;
    if (hr_step) begin
      hr_ones_d = bcd_inc(hr_ones_q);
      if (hr_ones_q == 4'd9) hr_tens_d = hr_tens_q + 4'd1;
      if (Mode24) begin
        if (hr_tens_q == 4'd2 && hr_ones_q == 4'd3) begin
          hr_tens_d = 4'd0;
          hr_ones_d = 4'd0;
        end
      end else if (hr_tens_q == 4'd1 && hr_ones_q == 4'd2) begin
        hr_tens_d = 4'd0;
        hr_ones_d = 4'd1;
      end else if (hr_tens_q == 4'd1 && hr_ones_q == 4'd1) begin
        pm_d = ~pm_q;
      end
    end
  end

  assign alarm_d = alarm_en_i
                && ({hr_tens_q, hr_ones_q} == {alarm_hr_t_i, alarm_hr_o_i})
                && ({min_tens_o, min_ones_o} == {alarm_min_t_i, alarm_min_o_i})
                && (Mode24 || (pm_q == alarm_pm_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      min_prev_q <= 1'b0;
      hr_prev_q  <= 1'b0;
      min_pend_q <= 1'b0;
      hr_pend_q  <= 1'b0;
      hr_tens_q  <= Mode24 ? RST_HR24_TENS : RST_HR12_TENS;
      hr_ones_q  <= Mode24 ? RST_HR24_ONES : RST_HR12_ONES;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      min_prev_q <= min_inc_i;
      hr_prev_q  <= hr_inc_i;
      min_pend_q <= min_pend_d;
      hr_pend_q  <= hr_pend_d;
      hr_tens_q  <= hr_tens_d;
      hr_ones_q  <= hr_ones_d;
      pm_q       <= pm_d;
      sec_tick_q <= tick;
      alarm_q    <= alarm_d;
    end
  end

  assign hr_tens_o  = hr_tens_q;
  assign hr_ones_o  = hr_ones_q;
  assign pm_o       = pm_q;
  assign sec_tick_o = sec_tick_q;
  assign alarm_o    = alarm_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper: 12-hour and 24-hour instances share stimulus and
// are checked against a seconds-of-day reference model.
module tb_clock_timekeeper;

  localparam int unsigned TD = 4;
  localparam int Budget = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic min_inc = 1'b0, hr_inc = 1'b0, sec_clr = 1'b0, alarm_en = 1'b0;
  int ah = 0, am = 0, a12_h;
  logic [3:0] a12_ht, a12_ho, a24_ht, a24_ho, a_mt, a_mo;
  logic a_pm;

  assign a12_h  = (ah % 12 == 0) ? 12 : ah % 12;
  assign a12_ht = 4'(a12_h / 10);
  assign a12_ho = 4'(a12_h % 10);
  assign a24_ht = 4'(ah / 10);
  assign a24_ho = 4'(ah % 10);
  assign a_mt   = 4'(am / 10);
  assign a_mo   = 4'(am % 10);
  assign a_pm   = (ah >= 12);

  logic [3:0] s1_12, s10_12, m1_12, m10_12, h1_12, h10_12;
  logic [3:0] s1_24, s10_24, m1_24, m10_24, h1_24, h10_24;
  logic pm_12, tk_12, al_12, pm_24, tk_24, al_24;
  logic [26:0] got12, got24;
  assign got12 = {h10_12, h1_12, m10_12, m1_12, s10_12, s1_12, pm_12, tk_12, al_12};
  assign got24 = {h10_24, h1_24, m10_24, m1_24, s10_24, s1_24, pm_24, tk_24, al_24};

  clock_timekeeper #(.TICK_DIV(TD), .HOUR_MODE(12)) dut12 (
    .clk_i(clk), .rst_ni(rst_n), .min_inc_i(min_inc), .hr_inc_i(hr_inc),
    .sec_clr_i(sec_clr), .alarm_en_i(alarm_en), .alarm_hr_t_i(a12_ht),
    .alarm_hr_o_i(a12_ho), .alarm_min_t_i(a_mt), .alarm_min_o_i(a_mo),
    .alarm_pm_i(a_pm), .sec_ones_o(s1_12), .sec_tens_o(s10_12), .min_ones_o(m1_12),
    .min_tens_o(m10_12), .hr_ones_o(h1_12), .hr_tens_o(h10_12), .pm_o(pm_12),
    .sec_tick_o(tk_12), .alarm_o(al_12)
  );

  clock_timekeeper #(.TICK_DIV(TD), .HOUR_MODE(24)) dut24 (
    .clk_i(clk), .rst_ni(rst_n), .min_inc_i(min_inc), .hr_inc_i(hr_inc),
    .sec_clr_i(sec_clr), .alarm_en_i(alarm_en), .alarm_hr_t_i(a24_ht),
    .alarm_hr_o_i(a24_ho), .alarm_min_t_i(a_mt), .alarm_min_o_i(a_mo),
    .alarm_pm_i(1'b0), .sec_ones_o(s1_24), .sec_tens_o(s10_24), .min_ones_o(m1_24),
    .min_tens_o(m10_24), .hr_ones_o(h1_24), .hr_tens_o(h10_24), .pm_o(pm_24),
    .sec_tick_o(tk_24), .alarm_o(al_24)
  );

  // Reference model: time as seconds since midnight, hour-of-day 0..23.
  int tod, presc;
  bit min_prev, hr_prev, min_pend, hr_pend, exp_tick, exp_alarm;
  int n_checks = 0, n_pass = 0;

  task automatic model_reset();
    tod = 0; presc = 0;
    min_prev = 0; hr_prev = 0; min_pend = 0; hr_pend = 0;
    exp_tick = 0; exp_alarm = 0;
  endtask

  task automatic model_step();
    int s, m, h;
    bit mp, hp, tick, cs, cm;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = tod % 60; m = (tod / 60) % 60; h = tod / 3600;
    exp_alarm = alarm_en && (h == ah) && (m == am);
    mp = min_pend || (min_inc && !min_prev);
    hp = hr_pend || (hr_inc && !hr_prev);
    tick = (presc == TD - 1) && !sec_clr;
    cs = tick && (s == 59);
    cm = cs && (m == 59);
    presc = (sec_clr || tick) ? 0 : presc + 1;
    if (tick) tod = (tod + 1) % 86400;
    if (sec_clr) tod = tod - tod % 60;
    s = tod % 60; m = (tod / 60) % 60; h = tod / 3600;
    if (mp && !cs) begin m = (m + 1) % 60; mp = 0; end
    if (hp && !cm) begin h = (h + 1) % 24; hp = 0; end
    tod = h * 3600 + m * 60 + s;
    min_pend = mp; hr_pend = hp;
    min_prev = min_inc; hr_prev = hr_inc;
    exp_tick = tick;
  endtask

  function automatic logic [26:0] exp_vec(input bit mode24);
    int h, m, s, hd;
    bit pm;
    h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
    if (mode24) begin
      hd = h; pm = 0;
    end else begin
      hd = (h % 12 == 0) ? 12 : h % 12; pm = (h >= 12);
    end
    return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            pm, exp_tick, exp_alarm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic pulse_hr(input int n);
    repeat (n) begin hr_inc = 1'b1; cyc(); hr_inc = 1'b0; cyc(); end
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin min_inc = 1'b1; cyc(); min_inc = 1'b0; cyc(); end
  endtask

  task automatic preset(input int h, input int m);
    do_reset();
    sec_clr = 1'b1;
    pulse_hr(h);
    pulse_min(m);
    sec_clr = 1'b0;
  endtask

  // Steps until the model reaches target (optionally on the cycle before a tick).
  task automatic run_to(input int target, input bit before_tick);
    int n = 0;
    while (!(tod == target && (!before_tick || presc == TD - 1)) && n < Budget) begin
      cyc();
      n++;
    end
    n_checks++;
    if (n >= Budget) $display("FAIL run_to timeout: target=%0d reached=%0d", target, tod);
    else n_pass++;
  endtask

  task automatic test_reset();
    int n = 0;
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    n_checks++;
    if (got12 !== {24'h120000, 3'b000}) $display("FAIL reset12 got=%h exp=%h", got12, {24'h120000, 3'b000});
    else n_pass++;
    n_checks++;
    if (got24 !== 27'h0) $display("FAIL reset24 got=%h exp=0", got24);
    else n_pass++;
    cyc();
    rst_n = 1'b1;
    do begin cyc(); n++; end while (!tk_12 && n < 20);
    n_checks++;
    if (n != TD || s1_12 !== 4'd1) $display("FAIL first_tick got=%0d/%0d exp=%0d/1", n, s1_12, TD);
    else n_pass++;
  endtask

  task automatic test_rollover();
    preset(11, 59);
    run_to(43199, 0);
    n_checks++;
    if (got12 !== exp_vec(0)) $display("FAIL pre_noon got=%h exp=%h", got12, exp_vec(0));
    else n_pass++;
    run_to(43200, 0);
    n_checks++;
    if (got12[26:1] !== {24'h120000, 2'b11}) $display("FAIL noon got=%h exp=%h", got12[26:1], {24'h120000, 2'b11});
    else n_pass++;
    preset(23, 59);
    run_to(86399, 0);
    n_checks++;
    if (got24[26:2] !== {24'h235959, 1'b0}) $display("FAIL pre_midnight24 got=%h exp=%h", got24[26:2], {24'h235959, 1'b0});
    else n_pass++;
    run_to(0, 0);
    n_checks++;
    if (got24[26:2] !== 25'h0) $display("FAIL midnight24 got=%h exp=0", got24[26:2]);
    else n_pass++;
    n_checks++;
    if (got12[26:2] !== {24'h120000, 1'b0}) $display("FAIL midnight12 got=%h exp=%h", got12[26:2], {24'h120000, 1'b0});
    else n_pass++;
  endtask

  task automatic test_manual();
    do_reset();
    sec_clr = 1'b1;
    pulse_hr(3);
    pulse_min(59);
    pulse_min(1);
    n_checks++;
    if (got12[26:3] !== 24'h030000) $display("FAIL min_wrap_no_carry got=%h exp=030000", got12[26:3]);
    else n_pass++;
    sec_clr = 1'b0;
    do_reset();
    pulse_hr(1);
    n_checks++;
    if (got12[26:2] !== {24'h010000, 1'b0}) $display("FAIL hr_12_to_01 got=%h exp=%h", got12[26:2], {24'h010000, 1'b0});
    else n_pass++;
  endtask

  task automatic test_conflict();
    preset(7, 10);
    run_to(7 * 3600 + 10 * 60 + 59, 1);
    min_inc = 1'b1;
    cyc();
    min_inc = 1'b0;
    n_checks++;
    if (got12[26:3] !== 24'h071100) $display("FAIL conflict_carry got=%h exp=071100", got12[26:3]);
    else n_pass++;
    cyc();
    n_checks++;
    if (got12[26:3] !== 24'h071200) $display("FAIL conflict_manual got=%h exp=071200", got12[26:3]);
    else n_pass++;
  endtask

  task automatic test_alarm();
    ah = 18; am = 30; alarm_en = 1'b1;
    preset(18, 29);
    run_to(66600, 0);
    n_checks++;
    if (got12 !== exp_vec(0) || al_12 !== 1'b0) $display("FAIL alarm_latency got=%h exp=%h", got12, exp_vec(0));
    else n_pass++;
    cyc();
    n_checks++;
    if (al_12 !== 1'b1 || al_24 !== 1'b1) $display("FAIL alarm_rise got=%b%b exp=11", al_12, al_24);
    else n_pass++;
    for (int i = 0; i < 300 && tod != 66660; i++) begin
      cyc();
      n_checks++;
      if (got12 !== exp_vec(0) || got24 !== exp_vec(1))
        $display("FAIL alarm_minute got=%h/%h exp=%h/%h", got12, got24, exp_vec(0), exp_vec(1));
      else n_pass++;
    end
    cyc();
    n_checks++;
    if (al_12 !== 1'b0) $display("FAIL alarm_end got=%b exp=0", al_12);
    else n_pass++;
    preset(6, 30);
    repeat (3) cyc();
    n_checks++;
    if (al_12 !== 1'b0) $display("FAIL alarm_am got=%b exp=0", al_12);
    else n_pass++;
    ah = 6;
    cyc();
    n_checks++;
    if (al_12 !== 1'b1 || al_24 !== 1'b1) $display("FAIL alarm_am_match got=%b%b exp=11", al_12, al_24);
    else n_pass++;
    alarm_en = 1'b0;
    cyc();
    n_checks++;
    if (al_12 !== 1'b0 || al_24 !== 1'b0) $display("FAIL alarm_disable got=%b%b exp=00", al_12, al_24);
    else n_pass++;
  endtask

  task automatic test_clr_reset();
    int n = 0;
    do_reset();
    repeat (30) cyc();
    sec_clr = 1'b1;
    repeat (300) cyc();
    n_checks++;
    if (got12[26:3] !== 24'h120000) $display("FAIL sec_clr_hold got=%h exp=120000", got12[26:3]);
    else n_pass++;
    sec_clr = 1'b0;
    repeat (6) cyc();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (got12 !== {24'h120000, 3'b000} || got24 !== 27'h0) $display("FAIL async_reset got=%h/%h exp=%h/0", got12, got24, {24'h120000, 3'b000});
    else n_pass++;
    cyc();
    rst_n = 1'b1;
    do begin cyc(); n++; end while (!tk_12 && n < 20);
    n_checks++;
    if (n != TD) $display("FAIL tick_after_reset got=%0d exp=%0d", n, TD);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      min_inc  = ($urandom % 5 == 0);
      hr_inc   = ($urandom % 7 == 0);
      sec_clr  = ($urandom % 30 == 0);
      alarm_en = ($urandom % 4 != 0);
      if (i % 64 == 0) begin
        ah = ($urandom % 2 == 0) ? tod / 3600 : $urandom_range(0, 23);
        am = ($urandom % 2 == 0) ? (tod / 60) % 60 : $urandom_range(0, 59);
      end
      cyc();
      n_checks++;
      if (got12 !== exp_vec(0) || got24 !== exp_vec(1))
        $display("FAIL random[%0d] got=%h/%h exp=%h/%h", i, got12, got24, exp_vec(0), exp_vec(1));
      else n_pass++;
    end
    min_inc = 1'b0; hr_inc = 1'b0; sec_clr = 1'b0; alarm_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_manual();
    test_conflict();
    test_alarm();
    test_clr_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_timekeeper.md
# clock_timekeeper

Parametrised BCD time-of-day core for the digital-clock design. It divides the system clock to a 1 Hz tick and keeps seconds, minutes and hours in BCD, in either 12-hour (AM/PM) or 24-hour format. It accepts manual minute/hour set pulses without losing a carry, and raises an alarm on a programmable HH:MM match. It feeds the display mux directly and replaces the free-running minute/hour counter clocked by a seconds pulse.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per second; must be ≥ 2; prescaler width is $clog2(TICK_DIV).
- `HOUR_MODE`, default 12: 12 (hours 01..12 plus `pm`) or 24 (hours 00..23, `pm` held 0); any other value is an elaboration error.
- `clk`  in  1  system clock; single clock domain, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `min_inc`  in  1  synchronous, pre-debounced level; each rising edge advances minutes by one.
- `hr_inc`  in  1  synchronous, pre-debounced level; each rising edge advances hours by one.
- `sec_clr`  in  1  level; while high, seconds and prescaler are held at 0.
- `alarm_en`  in  1  alarm enable.
- `alarm_hr_t`, `alarm_hr_o`, `alarm_min_t`, `alarm_min_o`  in  4 each  alarm time in BCD.
- `alarm_pm`  in  1  alarm AM/PM; ignored when HOUR_MODE=24.
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`, `hr_ones`, `hr_tens`  out  4 each  current time in BCD.
- `pm`  out  1  PM flag (12-hour mode only).
- `sec_tick`  out  1  one-cycle pulse coincident with each seconds update.
- `alarm`  out  1  alarm active.

## Operation
- Reset values:
  - 12-hour mode: 12:00:00, `pm`=0 (midnight).
  - 24-hour mode: 00:00:00.
  - `sec_tick`=0, `alarm`=0, prescaler=0, edge-detect history=0, pending bits=0.
- Prescaler: counts 0..TICK_DIV-1. At the terminal count it wraps to 0 and seconds advance.
- Seconds: 00..59; wrap 59→00 generates a minute carry.
- Minutes: 00..59; wrap 59→00 generates an hour carry.
- Hours, 12-hour mode: sequence 12→01→…→11→12. The 11→12 step toggles `pm`.
- Hours, 24-hour mode: 00..23, wrap to 00.
- Manual set:
  - A rising edge on `min_inc`/`hr_inc` sets that field's pending bit.
  - The pending bit is applied, and cleared, on the first cycle with no carry into that field.
  - Manual minute wrap 59→00 does NOT carry into hours.
  - Manual hour increment follows the same 11→12 `pm` toggle rule.
  - A second edge arriving while the pending bit is still set is merged (one increment).
- `sec_clr`:
  - Forces seconds and prescaler to 0 every cycle it is high; no minute carry occurs.
  - Manual increments still apply while it is high.
- Alarm:
  - `alarm` = registered(`alarm_en` & hours match & minutes match & (HOUR_MODE=24 | `pm`==`alarm_pm`)).
  - It stays high for the whole matching minute and drops one cycle after the match or `alarm_en` ends.
- Arithmetic is BCD per digit. No digit ever holds a value >9, and no tens digit exceeds its field limit (5 for sec/min, 1 or 2 for hours).

## Timing
- All outputs are registered.
- Prescaler terminal at cycle edge N: new seconds, and any rippled minute/hour, are visible after edge N. `sec_tick` is high for exactly the cycle following edge N. Full ripple to 00:00:00 happens in that same single edge.
- `min_inc`/`hr_inc` are sampled each edge. Rising edge seen (prev 0, now 1) at edge N with no conflicting carry: field is updated after edge N. With a conflicting carry: the carry applies at N and the manual increment at N+1.
- Minimum `inc` high/low width is 1 cycle.
- `alarm` latency is 1 cycle after the time/inputs satisfy the match.
- `rst_n` asserted mid-count: all state returns to reset values immediately (asynchronous). Counting resumes on the first edge after deassertion, with the prescaler starting from 0.

## Structure
- Package `clock_pkg` holds:
  - `bcd_t` (4-bit digit typedef).
  - Hour-mode constants HOUR_12/HOUR_24.
  - Reset time constants per mode.
  - A BCD increment function.
- Sub-module `bcd_mod60` covers the shared seconds/minutes logic:
  - ones/tens pair with `inc`, `clr`, and `wrap` out.
  - Instantiated twice.
- Hour logic, prescaler, edge detect/pending bits and alarm compare live in the top.

## Test plan
- Reset release (TICK_DIV=4, HOUR_MODE=12) → 12:00:00, `pm`=0. `sec_tick` first pulses 4 cycles later, with `sec_ones`=1.
- Preset 11:59:59 AM via increments, then one tick → 12:00:00, `pm`=1. With HOUR_MODE=24, 23:59:59 + tick → 00:00:00.
- `min_inc` edge at 03:59:xx → 03:00:xx; hours unchanged. `hr_inc` at 12 (12-hour mode) → 01, `pm` unchanged.
- `min_inc` rising on the same edge as rollover 07:10:59→07:11:00 → minutes 11 after that edge, 12 one cycle later, `sec_ones`/`sec_tens`=0.
- Alarm 06:30 PM, `alarm_en`=1: time reaches 06:30:00 PM → `alarm` high one cycle later, stays high through 06:30:59, low after 06:31:00. The same time in AM gives no alarm. Dropping `alarm_en` mid-minute → low next cycle.
- `sec_clr` held during a running count → seconds 00 with no minute carry. `rst_n` pulsed low mid-second → immediate reset values; the next `sec_tick` comes exactly TICK_DIV cycles after release.
